// File: rtl/inst_mem_ctrl_if.sv
// inst_mem_ctrl_if: bundles the core fetch port and the byte-wide external
// memory port of inst_mem_ctrl.
//   rom_ce_i     core -> ctrl   fetch request valid
//   rom_addr_i   core -> ctrl   byte address of requested instruction
//   rom_data_o   ctrl -> core   assembled instruction (valid with rom_ready_o)
//   rom_ready_o  ctrl -> core   one-cycle delivery pulse
//   stall_req_o  ctrl -> core   memory fetch in progress
//   mem_a_o      ctrl -> mem    byte address (ADDR_W bits)
//   mem_re_o     ctrl -> mem    read enable
//   mem_din_i    mem  -> ctrl   read byte, one cycle after its address
// Modport slave is the controller side, master is the core/memory side.
interface inst_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              rom_ready_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_re_o;
    logic [7:0]        mem_din_i;

    modport slave (
        input  rom_ce_i, rom_addr_i, mem_din_i,
        output rom_data_o, rom_ready_o, stall_req_o, mem_a_o, mem_re_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, mem_din_i,
        input  rom_data_o, rom_ready_o, stall_req_o, mem_a_o, mem_re_o
    );
endinterface

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: fetches 32-bit instructions from a byte-wide external memory
// with a one-entry instruction cache in front of it.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   bus  inst_mem_ctrl_if.slave (fetch request/response + external memory)
// A miss reads 4 consecutive bytes (little-endian, address wraps modulo
// 2^ADDR_W) and delivers 5 edges after acceptance. A hit delivers on the next
// edge. Dropping or changing the request during a fetch aborts it.
module inst_mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input logic            clk,
    input logic            rst,
    inst_mem_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       addr_q, addr_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       tag_q, tag_d;
    logic [31:0]       cdata_q, cdata_d;
    logic              valid_q, valid_d;
    logic [31:0]       rom_data_q, rom_data_d;
    logic              rom_ready_q, rom_ready_d;
    logic              stall_q, stall_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_re_q, mem_re_d;

    logic              hit;
    logic              req_match;
    logic [ADDR_W-1:0] next_a;

    assign hit       = valid_q && (tag_q == bus.rom_addr_i);
    assign req_match = bus.rom_ce_i && (bus.rom_addr_i == addr_q);
    assign next_a    = addr_q[ADDR_W-1:0] + ADDR_W'(k_q) + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            addr_q      <= '0;
            buf_q       <= '0;
            tag_q       <= '0;
            cdata_q     <= '0;
            valid_q     <= 1'b0;
            rom_data_q  <= '0;
            rom_ready_q <= 1'b0;
            stall_q     <= 1'b0;
            mem_a_q     <= '0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            tag_q       <= tag_d;
            cdata_q     <= cdata_d;
            valid_q     <= valid_d;
            rom_data_q  <= rom_data_d;
            rom_ready_q <= rom_ready_d;
            stall_q     <= stall_d;
            mem_a_q     <= mem_a_d;
            mem_re_q    <= mem_re_d;
        end
    end

    // k is the index of the byte address currently on mem_a_o. The two edges
    // after the last address (k==3) are told apart by mem_re_q: the first
    // drops the read enable, the second captures byte 3 straight from
    // mem_din_i and delivers.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        tag_d       = tag_q;
        cdata_d     = cdata_q;
        valid_d     = valid_q;
        rom_data_d  = rom_data_q;
        rom_ready_d = 1'b0;
        stall_d     = stall_q;
        mem_a_d     = mem_a_q;
        mem_re_d    = mem_re_q;

        unique case (state_q)
            IDLE: begin
                stall_d  = 1'b0;
                mem_re_d = 1'b0;
                k_d      = '0;
                if (bus.rom_ce_i) begin
                    if (hit) begin
                        rom_data_d  = cdata_q;
                        rom_ready_d = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        addr_d   = bus.rom_addr_i;
                        stall_d  = 1'b1;
                        mem_re_d = 1'b1;
                        mem_a_d  = bus.rom_addr_i[ADDR_W-1:0];
                    end
                end
            end

            FETCH: begin
                if (!req_match) begin
                    state_d  = IDLE;
                    stall_d  = 1'b0;
                    mem_re_d = 1'b0;
                    k_d      = '0;
                end else if (mem_re_q) begin
                    // Data for address index k-1 arrives this cycle.
                    case (k_q)
                        2'd1:    buf_d[7:0]   = bus.mem_din_i;
                        2'd2:    buf_d[15:8]  = bus.mem_din_i;
                        2'd3:    buf_d[23:16] = bus.mem_din_i;
                        default: ;
                    endcase
                    if (k_q != 2'd3) begin
                        k_d     = k_q + 2'd1;
                        mem_a_d = next_a;
                    end else begin
                        mem_re_d = 1'b0;
                    end
                end else begin
                    state_d     = IDLE;
                    rom_data_d  = {bus.mem_din_i, buf_q};
                    rom_ready_d = 1'b1;
                    stall_d     = 1'b0;
                    tag_d       = addr_q;
                    cdata_d     = {bus.mem_din_i, buf_q};
                    valid_d     = 1'b1;
                    k_d         = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_data_o  = rom_data_q;
    assign bus.rom_ready_o = rom_ready_q;
    assign bus.stall_req_o = stall_q;
    assign bus.mem_a_o     = mem_a_q;
    assign bus.mem_re_o    = mem_re_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: directed bench for inst_mem_ctrl with a transaction-level
// reference model compared against the DUT every cycle.
module tb_inst_mem_ctrl;
    localparam int unsigned AW    = 17;
    localparam int unsigned MEMSZ = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    logic [7:0]    mem [0:MEMSZ-1];
    logic [AW-1:0] aseq [0:3];

    inst_mem_ctrl_if #(.ADDR_W(AW)) bus ();
    inst_mem_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // External memory: byte at the previous cycle's address.
    always @(posedge clk) bus.mem_din_i <= mem[bus.mem_a_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0]   w;
        logic [AW-1:0] idx;
        w = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = AW'(a + 32'(k));
            w[8*k +: 8] = mem[idx];
        end
        return w;
    endfunction

    // Reference model: counts edges since a fetch was accepted.
    bit            m_fetch = 0;
    int            m_n     = 0;
    logic [31:0]   m_addr  = '0;
    logic [31:0]   m_tag   = '0;
    logic [31:0]   m_cdata = '0;
    bit            m_valid = 0;
    logic [31:0]   m_data  = '0;
    bit            m_ready = 0;
    bit            m_re    = 0;
    logic [AW-1:0] m_a     = '0;

    always @(posedge clk) begin
        m_ready = 0;
        if (!rst) begin
            m_fetch = 0; m_n = 0; m_addr = '0; m_tag = '0; m_cdata = '0;
            m_valid = 0; m_data = '0; m_re = 0; m_a = '0;
        end else if (!m_fetch) begin
            if (bus.rom_ce_i) begin
                if (m_valid && m_tag == bus.rom_addr_i) begin
                    m_data  = m_cdata;
                    m_ready = 1;
                end else begin
                    m_fetch = 1;
                    m_n     = 0;
                    m_addr  = bus.rom_addr_i;
                    m_a     = AW'(bus.rom_addr_i);
                    m_re    = 1;
                end
            end
        end else if (!bus.rom_ce_i || bus.rom_addr_i != m_addr) begin
            m_fetch = 0;
            m_re    = 0;
        end else begin
            m_n++;
            if (m_n <= 3) m_a = AW'(m_addr + 32'(m_n));
            if (m_n == 4) m_re = 0;
            if (m_n == 5) begin
                m_fetch = 0;
                m_data  = word_at(m_addr);
                m_ready = 1;
                m_tag   = m_addr;
                m_cdata = m_data;
                m_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rom_ready_o", 32'(bus.rom_ready_o), 32'(m_ready));
            chk("cyc_stall_req_o", 32'(bus.stall_req_o), 32'(m_fetch));
            chk("cyc_mem_re_o",    32'(bus.mem_re_o),    32'(m_re));
            chk("cyc_mem_a_o",     32'(bus.mem_a_o),     32'(m_a));
            chk("cyc_rom_data_o",  bus.rom_data_o,       m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests address a and waits for the delivery pulse. lat counts edges
    // after the accept edge (0 for a hit, 5 for a miss), -1 on timeout.
    task automatic run_req(input logic [31:0] a, output int lat, output int stalls,
                           output logic [31:0] data, output bit re_seen, output bit stall_at_rdy);
        bus.rom_ce_i   = 1'b1;
        bus.rom_addr_i = a;
        lat = -1; stalls = 0; data = '0; re_seen = 0; stall_at_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 4) aseq[i] = bus.mem_a_o;
            if (bus.stall_req_o) stalls++;
            if (bus.mem_re_o) re_seen = 1;
            if (bus.rom_ready_o) begin
                lat          = i;
                data         = bus.rom_data_o;
                stall_at_rdy = bus.stall_req_o;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, stalls;
        logic [31:0] data;
        bit          re_seen, sar;
        logic [31:0] b2b_addr [0:2];
        logic [31:0] b2b_word [0:2];

        for (int unsigned i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
        mem[4] = 8'h13; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;
        mem[8] = 8'hEF; mem[9] = 8'hBE; mem[10] = 8'hAD; mem[11] = 8'hDE;
        mem[32'h20] = 8'h78; mem[32'h21] = 8'h56; mem[32'h22] = 8'h34; mem[32'h23] = 8'h12;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[MEMSZ-2] = 8'hAA; mem[MEMSZ-1] = 8'hBB;

        rst = 1'b0; bus.rom_ce_i = 1'b0; bus.rom_addr_i = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_ready", 32'(bus.rom_ready_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("rst_data",  bus.rom_data_o,       32'd0);
        chk("rst_mem_a", 32'(bus.mem_a_o),     32'd0);
        rst = 1'b1;
        step();

        // Miss on 0x4.
        run_req(32'h4, lat, stalls, data, re_seen, sar);
        chk("miss_latency", 32'(lat),    32'd5);
        chk("miss_stalls",  32'(stalls), 32'd5);
        chk("miss_data",    data,        32'h00100513);

        // Immediate repeat hits.
        run_req(32'h4, lat, stalls, data, re_seen, sar);
        chk("hit_latency", 32'(lat),     32'd0);
        chk("hit_mem_re",  32'(re_seen), 32'd0);
        chk("hit_data",    data,         32'h00100513);
        bus.rom_ce_i = 1'b0;
        step();

        // Abort: miss on 0x8, switch to 0x20 before E2.
        bus.rom_ce_i = 1'b1; bus.rom_addr_i = 32'h8;
        step(); step();
        bus.rom_addr_i = 32'h20;
        step();
        chk("abort_stall", 32'(bus.stall_req_o), 32'd0);
        chk("abort_ready", 32'(bus.rom_ready_o), 32'd0);
        run_req(32'h20, lat, stalls, data, re_seen, sar);
        chk("abort_new_latency", 32'(lat), 32'd5);
        chk("abort_new_data",    data,     32'h12345678);
        bus.rom_ce_i = 1'b0;
        step();

        // Address wrap at the top of the 17-bit space.
        run_req(32'h0001FFFE, lat, stalls, data, re_seen, sar);
        chk("wrap_a0", 32'(aseq[0]), 32'h1FFFE);
        chk("wrap_a1", 32'(aseq[1]), 32'h1FFFF);
        chk("wrap_a2", 32'(aseq[2]), 32'h00000);
        chk("wrap_a3", 32'(aseq[3]), 32'h00001);
        chk("wrap_data", data, 32'h2211BBAA);
        bus.rom_ce_i = 1'b0;
        step();

        // Reset during a fetch, asserted for edge E3.
        bus.rom_ce_i = 1'b1; bus.rom_addr_i = 32'h8;
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("midrst_ready", 32'(bus.rom_ready_o), 32'd0);
        chk("midrst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("midrst_re",    32'(bus.mem_re_o),    32'd0);
        chk("midrst_a",     32'(bus.mem_a_o),     32'd0);
        chk("midrst_data",  bus.rom_data_o,       32'd0);
        rst = 1'b1;
        run_req(32'h8, lat, stalls, data, re_seen, sar);
        chk("postrst_latency", 32'(lat), 32'd5);
        chk("postrst_data",    data,     32'hDEADBEEF);
        bus.rom_ce_i = 1'b0;
        step();

        // Back-to-back misses, next request presented right after each pulse.
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        b2b_word[0] = 32'h44332211; b2b_word[1] = 32'h00100513; b2b_word[2] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            run_req(b2b_addr[i], lat, stalls, data, re_seen, sar);
            chk("b2b_latency",      32'(lat),    32'd5);
            chk("b2b_stall_at_rdy", 32'(sar),    32'd0);
            chk("b2b_stalls",       32'(stalls), 32'd5);
            chk("b2b_data",         data,        b2b_word[i]);
        end
        bus.rom_ce_i = 1'b0;
        step(); step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_mem_ctrl.md
INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 17, byte-address width of external instruction memory.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset.
REQ-004 Port: rom_ce_i  input  1  fetch request from core, high = request valid.
REQ-005 Port: rom_addr_i  input  32  byte address of requested instruction.
REQ-006 Port: rom_data_o  output  32  assembled instruction, valid while rom_ready_o high.
REQ-007 Port: rom_ready_o  output  1  one-cycle pulse, instruction delivered.
REQ-008 Port: stall_req_o  output  1  high while a memory fetch is in progress.
REQ-009 Port: mem_a_o  output  ADDR_W  byte address to external memory.
REQ-010 Port: mem_re_o  output  1  read enable to external memory.
REQ-011 Port: mem_din_i  input  8  read byte; value in cycle n+1 is the byte at mem_a_o of cycle n.

Function
REQ-012 States SHALL be IDLE, FETCH; 2-bit byte counter k; single-entry cache (tag 32 bits, data 32 bits, valid bit).
REQ-013 IDLE, edge with rom_ce_i=1, cache valid, tag==rom_addr_i: hit; rom_data_o<=cache data, rom_ready_o<=1 for one cycle, no memory access, stay IDLE.
REQ-014 IDLE, edge with rom_ce_i=1 and miss: accept at edge E0; latch rom_addr_i; enter FETCH; stall_req_o<=1; mem_re_o<=1; mem_a_o<=addr[ADDR_W-1:0].
REQ-015 Byte k address (addr+k, k=0..3) SHALL be on mem_a_o in the cycle following edge Ek; mem_re_o high after E0..E3, low after E4.
REQ-016 Byte k SHALL be sampled from mem_din_i at edge E(k+2); assembly little-endian: byte k -> bits [8k+7:8k].
REQ-017 At E5: rom_data_o<=assembled word, rom_ready_o<=1, stall_req_o<=0, cache tag/data updated, valid<=1, return to IDLE; miss latency 5 edges.
REQ-018 rom_ready_o SHALL be high for exactly one cycle per delivery; rom_data_o holds last delivered value otherwise.
REQ-019 Address arithmetic addr+k SHALL wrap modulo 2^ADDR_W; rom_addr_i bits above ADDR_W ignored for memory addressing, all 32 bits used for cache tag.
REQ-020 Misaligned addresses SHALL be fetched as-is (4 consecutive bytes), no alignment fault.
REQ-021 In FETCH, any edge E1..E5 with rom_ce_i=0 or rom_addr_i != latched address: abort; return to IDLE, stall_req_o<=0, mem_re_o<=0, no rom_ready_o, cache unchanged.
REQ-022 After abort, new request SHALL be accepted no earlier than the edge following the abort edge.
REQ-023 IDLE with rom_ce_i=0: rom_ready_o, stall_req_o, mem_re_o SHALL be 0.
REQ-024 A hit and a FETCH SHALL never overlap; requests during FETCH are not queued.

Reset
REQ-025 At any edge with rst=0: state IDLE, k=0, cache valid=0, tag=0, cache data=0, rom_data_o=0, rom_ready_o=0, stall_req_o=0, mem_re_o=0, mem_a_o=0.
REQ-026 Reset mid-FETCH SHALL abort immediately, no delivery, no cache update; first post-reset request is a miss.

Verification
REQ-027 Miss: rst released, rom_ce_i=1, addr=0x00000004, memory bytes 0x13,0x05,0x10,0x00 at 4..7 -> rom_ready_o pulse exactly 5 edges after accept, rom_data_o=0x00100513, stall_req_o high 5 cycles.
REQ-028 Hit: repeat addr=0x00000004 immediately after REQ-027 -> rom_ready_o one cycle after request edge, mem_re_o stays 0, rom_data_o=0x00100513.
REQ-029 Abort: miss on 0x8, change rom_addr_i to 0x20 at E2 -> no ready for 0x8, IDLE at E2, new fetch of 0x20 accepted at E3, delivers at E8.
REQ-030 Wrap: ADDR_W=17, addr=0x0001FFFE -> mem_a_o sequence 0x1FFFE,0x1FFFF,0x00000,0x00001; word assembled from those bytes.
REQ-031 Reset mid-fetch: rst=0 at E3 -> all outputs 0 next cycle; re-request same address -> full 5-edge miss.
REQ-032 Back-to-back: addresses 0x0,0x4,0x8 each held until ready -> three pulses, stall_req_o drops exactly on each ready cycle.
